// File: rtl/sia_pkg.sv
// Shared definitions for the SIA UART: register map, bit positions
// of STAT/CTRL/IEN, and the state encoding used by both engines.
package sia_pkg;

    localparam logic [1:0] ADR_STAT = 2'd0;
    localparam logic [1:0] ADR_DATA = 2'd1;
    localparam logic [1:0] ADR_DIV  = 2'd2;
    localparam logic [1:0] ADR_IEN  = 2'd3;

    localparam int ST_RX_NEMPTY = 0;
    localparam int ST_RX_FULL   = 1;
    localparam int ST_TX_EMPTY  = 2;
    localparam int ST_TX_FULL   = 3;
    localparam int ST_TX_IDLE   = 4;
    localparam int ST_OVR       = 5;
    localparam int ST_FERR      = 6;

    localparam int CT_STOP2    = 0;
    localparam int CT_LOOP     = 1;
    localparam int CT_CLR_OVR  = 5;
    localparam int CT_CLR_FERR = 6;
    localparam int CT_FLUSH_TX = 8;
    localparam int CT_FLUSH_RX = 9;

    localparam int IE_RX  = 0;
    localparam int IE_TX  = 1;
    localparam int IE_ERR = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } eng_state_t;

endpackage

// File: rtl/sia_uart_if.sv
// Wishbone B4 16-bit slave bundle for the SIA UART.
// master drives cyc/stb/we/sel/adr/dat_i; slave returns ack/dat_o/stall.
interface sia_uart_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [1:0]  sel_i;
    logic [1:0]  adr_i;
    logic [15:0] dat_i;
    logic        ack_o;
    logic [15:0] dat_o;
    logic        stall_o;

    modport master (
        output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        input  ack_o, dat_o, stall_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        output ack_o, dat_o, stall_o
    );
endinterface

// File: rtl/sia_fifo.sv
// Synchronous FIFO with push/pop/flush; flush wins over push and pop.
// Ports: clk_i, reset_i (async low), push/din, pop/dout, flush, full, empty, level.
module sia_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  pop,
    input  logic                  flush,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (DEPTH_LOG2+1)'(DEPTH));
    // A pop on a full FIFO frees the slot the same-cycle push needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                level <= level + 1'b1;
            else if (do_pop && !do_push)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/sia_uart.sv
// SIA UART: Wishbone slave with divisor, TX/RX FIFOs, framing, loopback, irq.
// Ports: clk_i, reset_i (async low), wb (slave bus), rxd_i, txd_o, irq_o.
module sia_uart
    import sia_pkg::*;
#(
    parameter int          DATA_BITS     = 8,
    parameter int          TX_DEPTH_LOG2 = 3,
    parameter int          RX_DEPTH_LOG2 = 3,
    parameter int          DIV_WIDTH     = 16,
    parameter logic [15:0] DEFAULT_DIV   = 16'd433
) (
    input  logic       clk_i,
    input  logic       reset_i,
    sia_uart_if.slave  wb,
    input  logic       rxd_i,
    output logic       txd_o,
    output logic       irq_o
);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    // bus decode
    logic req, wr, rd;
    logic is_stat, is_data, is_div, is_ien;
    logic [15:0] rd_data;
    logic        ack_q;
    logic [15:0] dat_q;

    // registers
    logic [DIV_WIDTH-1:0] div_q;
    logic                 stop2_q, loop_q;
    logic [2:0]           ien_q;
    logic                 ovr_q, ferr_q, irq_q;

    // fifos
    logic                   tx_push, tx_pop, tx_full, tx_empty, flush_tx;
    logic [DATA_BITS-1:0]   tx_dout;
    logic [TX_DEPTH_LOG2:0] tx_level;
    logic                   rx_push, rx_pop, rx_full, rx_empty, flush_rx;
    logic [DATA_BITS-1:0]   rx_dout;
    logic [RX_DEPTH_LOG2:0] rx_level;

    // tx engine
    eng_state_t           tx_state_q, tx_state_d;
    logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_stop_q, tx_stop_d;
    logic                 txd_q, txd_d, tx_load;

    // rx engine
    eng_state_t           rx_state_q, rx_state_d;
    logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [DIV_WIDTH-1:0] half_div;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [1:0]           rx_sync;
    logic                 rx_in, rx_prev_q;
    logic                 ovr_set, ferr_set, clr_ovr, clr_ferr;

    logic unused;
    assign unused = ^{wb.sel_i[1], wb.dat_i, tx_level};

    assign req     = wb.cyc_i & wb.stb_i;
    assign wr      = req & wb.we_i & wb.sel_i[0];
    assign rd      = req & ~wb.we_i;
    assign is_stat = (wb.adr_i == ADR_STAT);
    assign is_data = (wb.adr_i == ADR_DATA);
    assign is_div  = (wb.adr_i == ADR_DIV);
    assign is_ien  = (wb.adr_i == ADR_IEN);

    assign tx_push  = wr & is_data;
    assign rx_pop   = rd & is_data & ~rx_empty;
    assign flush_tx = wr & is_stat & wb.dat_i[CT_FLUSH_TX];
    assign flush_rx = wr & is_stat & wb.dat_i[CT_FLUSH_RX];
    assign clr_ovr  = wr & is_stat & wb.dat_i[CT_CLR_OVR];
    assign clr_ferr = wr & is_stat & wb.dat_i[CT_CLR_FERR];

    assign wb.ack_o   = ack_q;
    assign wb.dat_o   = dat_q;
    assign wb.stall_o = 1'b0;
    assign txd_o      = loop_q ? 1'b1 : txd_q;
    assign irq_o      = irq_q;

    sia_fifo #(.WIDTH(DATA_BITS), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .push   (tx_push),
        .din    (wb.dat_i[DATA_BITS-1:0]),
        .pop    (tx_pop),
        .flush  (flush_tx),
        .dout   (tx_dout),
        .full   (tx_full),
        .empty  (tx_empty),
        .level  (tx_level)
    );

    sia_fifo #(.WIDTH(DATA_BITS), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .push   (rx_push),
        .din    (rx_shift_q),
        .pop    (rx_pop),
        .flush  (flush_rx),
        .dout   (rx_dout),
        .full   (rx_full),
        .empty  (rx_empty),
        .level  (rx_level)
    );

    always_comb begin
        rd_data = '0;
        unique case (1'b1)
            is_stat: begin
                rd_data[15:8]         = 8'(rx_level);
                rd_data[ST_RX_NEMPTY] = ~rx_empty;
                rd_data[ST_RX_FULL]   = rx_full;
                rd_data[ST_TX_EMPTY]  = tx_empty;
                rd_data[ST_TX_FULL]   = tx_full;
                rd_data[ST_TX_IDLE]   = tx_empty & (tx_state_q == S_IDLE);
                rd_data[ST_OVR]       = ovr_q;
                rd_data[ST_FERR]      = ferr_q;
            end
            is_data: begin
                if (!rx_empty)
                    rd_data = {1'b1, {(15-DATA_BITS){1'b0}}, rx_dout};
            end
            is_div:  rd_data = 16'(div_q);
            is_ien:  rd_data = {13'b0, ien_q};
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            div_q   <= DIV_WIDTH'(DEFAULT_DIV);
            stop2_q <= 1'b0;
            loop_q  <= 1'b0;
            ien_q   <= '0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            ack_q <= req;
            dat_q <= rd ? rd_data : '0;
            if (wr && is_stat) begin
                stop2_q <= wb.dat_i[CT_STOP2];
                loop_q  <= wb.dat_i[CT_LOOP];
            end
            if (wr && is_div) div_q <= wb.dat_i[DIV_WIDTH-1:0];
            if (wr && is_ien) ien_q <= wb.dat_i[2:0];
            // a set in the same cycle as the clear survives
            ovr_q  <= ovr_set  | (ovr_q  & ~clr_ovr);
            ferr_q <= ferr_set | (ferr_q & ~clr_ferr);
            irq_q  <= |(ien_q & {ovr_q | ferr_q, tx_empty, ~rx_empty});
        end
    end

    // ---------------- transmitter ----------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_stop_q  <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_stop_q  <= tx_stop_d;
            txd_q      <= txd_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_stop_d  = tx_stop_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        tx_load    = 1'b0;
        unique case (tx_state_q)
            S_IDLE: tx_load = ~tx_empty;
            S_START: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = S_DATA;
                    tx_cnt_d   = tx_div_q;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = tx_div_q;
                    if (tx_bit_q == LAST_BIT) begin
                        tx_state_d = S_STOP;
                        tx_stop_d  = stop2_q;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == '0) begin
                    if (tx_stop_q) begin
                        tx_stop_d = 1'b0;
                        tx_cnt_d  = tx_div_q;
                    end else if (!tx_empty) begin
                        // next start bit follows the stop bit directly
                        tx_load = 1'b1;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
        endcase
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_dout;
            tx_div_d   = div_q;
            tx_cnt_d   = div_q;
            txd_d      = 1'b0;
            tx_state_d = S_START;
        end
    end

    // ---------------- receiver ----------------
    // (DIV+1)/2 without a wider adder
    assign half_div = {1'b0, div_q[DIV_WIDTH-1:1]}
                    + {{(DIV_WIDTH-1){1'b0}}, div_q[0]};
    assign rx_in = loop_q ? txd_q : rx_sync[1];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rx_sync    <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_sync    <= {rx_sync[0], rxd_i};
            rx_prev_q  <= rx_in;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // Re-arming needs a falling edge, so after a framing error the
    // engine implicitly waits for the line to return high.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        ovr_set    = 1'b0;
        ferr_set   = 1'b0;
        unique case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_in) begin
                    rx_state_d = S_START;
                    rx_div_d   = div_q;
                    rx_cnt_d   = half_div;
                end
            end
            S_START: begin
                if (rx_cnt_q == '0) begin
                    if (rx_in) begin
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_state_d = S_DATA;
                        rx_cnt_d   = rx_div_q;
                        rx_bit_d   = '0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rx_in, rx_shift_q[DATA_BITS-1:1]};
                    rx_cnt_d   = rx_div_q;
                    if (rx_bit_q == LAST_BIT)
                        rx_state_d = S_STOP;
                    else
                        rx_bit_d = rx_bit_q + 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = S_IDLE;
                    if (!rx_in)
                        ferr_set = 1'b1;
                    else if (rx_full)
                        ovr_set = 1'b1;
                    else
                        rx_push = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
        endcase
    end
endmodule

// File: doc/sia_uart.md
Name: sia_uart

Overview:
- Parametrised successor to the SIA serial interface: a 16-bit Wishbone B4 slave that fronts an EIA-232-style asynchronous transmitter and receiver.
- Adds a programmable bit-rate divisor, TX/RX FIFOs, configurable character width, one or two stop bits, sticky error flags, internal loopback and a level interrupt.
- Sits on the I/O bus beside other slaves; the serial pins go to the board.

Parameters:
- DATA_BITS, 8, character width 5..8; unused high data bits read 0 and are ignored on write.
- TX_DEPTH_LOG2, 3, TX FIFO holds 2**TX_DEPTH_LOG2 characters.
- RX_DEPTH_LOG2, 3, RX FIFO holds 2**RX_DEPTH_LOG2 characters.
- DIV_WIDTH, 16, divisor register width, 4..16.
- DEFAULT_DIV, 16'd433, reset divisor; bit time is DIV+1 clocks.

Ports:
- clk_i  in  1  sole clock.
- reset_i  in  1  asynchronous, active-low reset.
- cyc_i  in  1  Wishbone cycle.
- stb_i  in  1  Wishbone strobe.
- we_i  in  1  write enable.
- sel_i  in  2  byte selects; a write needs sel_i[0], reads ignore it.
- adr_i  in  2  halfword register select, bits [2:1].
- dat_i  in  16  write data.
- ack_o  out  1  transfer acknowledge.
- dat_o  out  16  read data.
- stall_o  out  1  tied 0.
- rxd_i  in  1  serial input, idle high, asynchronous.
- txd_o  out  1  serial output, idle high.
- irq_o  out  1  level interrupt.

Behaviour:
- Reset (reset_i low, async) drives: ack_o=0, dat_o=0, txd_o=1, irq_o=0.
  - FIFOs empty, flags clear, divisor=DEFAULT_DIV, control=0, int-enable=0.
  - Both engines return to idle; an in-flight character is aborted.
- Bus: access registered when cyc_i&stb_i. ack_o=1 exactly one cycle later for one cycle; dat_o is valid while ack_o=1 and is 0 otherwise. There are no wait states. Side effects (push, pop, clear) occur on the registering edge.
- adr 0, STAT read:
  - [0] rx_nempty, [1] rx_full, [2] tx_empty, [3] tx_full.
  - [4] tx_idle (FIFO empty and shifter idle).
  - [5] overrun, [6] framing error.
  - [15:8] RX level.
- adr 0, CTRL write:
  - [0] stop2, [1] loopback.
  - [5] and [6] are write-1-to-clear for the matching flags.
  - [8] flush TX FIFO; the current character still completes.
  - [9] flush RX FIFO.
  - CTRL bits [1:0] read back at STAT is not provided; STAT is status only.
- adr 1, DATA:
  - Write pushes dat_i[DATA_BITS-1:0] into the TX FIFO. If the FIFO is full, the write is dropped silently and still acked.
  - Read returns {valid, 0s, rxdata}, with valid in bit 15, and pops one entry. Reading an empty FIFO returns 0 with no pop.
- adr 2, DIV: read/write; bit time is DIV+1 clocks. Writes take effect at the next character boundary of each engine.
- adr 3, IEN: [0] rx_nempty, [1] tx_empty, [2] error (overrun|ferr). irq_o is a registered OR of enabled conditions, one cycle of latency.
- TX engine, states IDLE -> START -> DATA -> STOP:
  - Leaves IDLE when the FIFO is non-empty and pops one entry.
  - txd_o goes to 0 (start bit) on the second edge after a push into an empty idle engine.
  - Each bit lasts DIV+1 clocks; data goes out LSB first.
  - STOP lasts 1 bit time, or 2 if stop2=1.
  - Back-to-back characters have no extra idle gap.
- RX engine:
  - rxd_i passes through 2 synchroniser flops.
  - States IDLE -> START -> DATA -> STOP.
  - A falling edge in IDLE starts a count of (DIV+1)/2. If the line is then high, it is a false start and the engine returns to IDLE.
  - After a valid start, it samples every DIV+1 clocks: DATA_BITS data bits, then one stop bit. Only one stop bit is checked regardless of stop2.
  - Stop bit 0: ferr set, character discarded, then the engine waits for the line high before re-arming.
  - Stop bit 1 with FIFO full: overrun set, character discarded.
  - Stop bit 1 with FIFO not full: character pushed.
- Simultaneous events:
  - Bus pop and RX push in the same cycle: both take effect, level unchanged.
  - TX pop and bus push in the same cycle: likewise.
  - Flush and push in the same cycle: flush wins.
  - Flag set and W1C in the same cycle: set wins.
- Loopback=1: the receiver input is the internal TX line, txd_o is held 1, and rxd_i is ignored.
- Divisor 0: bit time of 1 clock; the RX half-bit count is 0, i.e. sample on the next edge.

Decomposition:
- Package sia_pkg holds:
  - register addresses (STAT/DATA/DIV/IEN);
  - STAT, CTRL and IEN bit positions;
  - engine state encodings (IDLE/START/DATA/STOP).
- One sub-module, sia_fifo: a parametrised synchronous FIFO (WIDTH, DEPTH_LOG2).
  - Inputs: push, pop, flush.
  - Outputs: full, empty, level.
  - Simultaneous push and pop on full or empty is legal.
  - Instantiated twice, for TX and RX.

Test Plan:
- Reset mid-character: DIV=7, write 0x55, assert reset_i low during bit 3 -> txd_o=1 immediately; after release STAT reads 0x0014 and DIV reads DEFAULT_DIV.
- TX framing: DIV=7, stop2=1, write 0x55 -> on txd_o, 0 for 8 clocks, then 1,0,1,0,1,0,1,0 (8 clocks each), then 1 for 16 clocks; tx_idle=1 afterwards.
- Loopback burst: loopback=1, write 0x41,0x42,0x43 back-to-back -> RX level reaches 3; DATA reads 0x8041, 0x8042, 0x8043, then 0x0000.
- RX overrun: RX_DEPTH_LOG2=3, drive 9 characters on rxd_i -> level=8 and STAT[5]=1; writing CTRL 0x0020 clears it.
- Framing and glitch: a stop bit driven 0 -> STAT[6]=1 and nothing pushed; a 2-clock low glitch with DIV=15 -> false start, nothing pushed, no flags set.
- IRQ and bus timing: IEN=0x0001, loopback one character -> irq_o rises one cycle after rx_nempty and falls one cycle after the pop; every access shows ack_o exactly one cycle after stb_i and stall_o=0.
